// File: rtl/sa_edge_feeder.sv
// sa_edge_feeder: loads an NxN int8 weight tile down the north edge, then streams skewed activations into the west edge.
// Latency: weight beat -> north edge 1 cycle; activation lane r -> west row r in r+1 cycles; tile_done N+1 cycles after the a_last beat.
// Backpressure: w_ready only in IDLE/LOAD, a_ready only in STREAM; define SA_FEEDER_PERF_EN for tile_count/stall_cycles.
module sa_edge_feeder #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [N*DW-1:0] w_data,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [N*DW-1:0] a_data,
  input  logic            a_last,
  output logic [N*DW-1:0] north_weight,
  output logic [N-1:0]    north_accept_w,
  output logic [N*DW-1:0] west_input,
  output logic [N-1:0]    west_valid,
  output logic [N-1:0]    west_switch,
  output logic            busy,
  output logic            tile_done
`ifdef SA_FEEDER_PERF_EN
  ,
  output logic [31:0]     tile_count,
  output logic [31:0]     stall_cycles
`endif
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          sw_pend;
  logic          w_hs;
  logic          a_hs;

  // Readies are registered and only ever high in their own phase, so the handshakes are phase-qualified already.
  assign w_hs = w_valid & w_ready;
  assign a_hs = a_valid & a_ready;
  assign busy = (state != IDLE);

  // cnt counts accepted weight beats in LOAD and elapsed cycles in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      w_ready   <= 1'b0;
      a_ready   <= 1'b0;
      sw_pend   <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      case (state)
        IDLE: begin
          w_ready <= 1'b1;
          if (w_hs) begin
            state <= LOAD;
            cnt   <= CW'(1);
          end
        end
        LOAD: begin
          if (w_hs && cnt == LAST_IDX) begin
            state   <= STREAM;
            cnt     <= '0;
            w_ready <= 1'b0;
            a_ready <= 1'b1;
            sw_pend <= 1'b1;
          end else if (w_hs) begin
            cnt <= cnt + CW'(1);
          end
        end
        STREAM: begin
          if (a_hs) begin
            sw_pend <= 1'b0;
            if (a_last) begin
              state   <= DRAIN;
              a_ready <= 1'b0;
            end
          end
        end
        default: begin
          if (cnt == LAST_IDX) begin
            state     <= IDLE;
            cnt       <= '0;
            w_ready   <= 1'b1;
            tile_done <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // Idle cycles drive zeros so the PEs hold their inactive weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      north_weight   <= '0;
      north_accept_w <= '0;
    end else begin
      north_weight   <= w_hs ? w_data : '0;
      north_accept_w <= w_hs ? '1 : '0;
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    logic [DW-1:0] d_q [0:r];
    logic          v_q [0:r];
    logic          s_q [0:r];

    // Row r is delayed r+1 cycles; the switch flag rides in the same line as its data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= r; k++) begin
          d_q[k] <= '0;
          v_q[k] <= 1'b0;
          s_q[k] <= 1'b0;
        end
      end else begin
        d_q[0] <= a_hs ? a_data[r*DW +: DW] : '0;
        v_q[0] <= a_hs;
        s_q[0] <= a_hs & sw_pend;
        for (int k = 1; k <= r; k++) begin
          d_q[k] <= d_q[k-1];
          v_q[k] <= v_q[k-1];
          s_q[k] <= s_q[k-1];
        end
      end
    end

    assign west_input[r*DW +: DW] = d_q[r];
    assign west_valid[r]          = v_q[r];
    assign west_switch[r]         = s_q[r];
  end

`ifdef SA_FEEDER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_count   <= '0;
      stall_cycles <= '0;
    end else begin
      if (tile_done)
        tile_count <= tile_count + 32'd1;
      if ((state == LOAD && !w_hs) || (state == STREAM && !a_hs))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sa_edge_feeder.sv
// tb_sa_edge_feeder: random and directed tiles against a cycle-indexed expectation table built from accepted handshakes.
// Also models the PE column shift to confirm each tile lands with row 0 on top.
`timescale 1ns/1ps
module tb_sa_edge_feeder;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXC = 4096;
  localparam int MAXV = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            w_valid = 1'b0;
  logic            w_ready;
  logic [N*DW-1:0] w_data = '0;
  logic            a_valid = 1'b0;
  logic            a_ready;
  logic [N*DW-1:0] a_data = '0;
  logic            a_last = 1'b0;
  logic [N*DW-1:0] north_weight;
  logic [N-1:0]    north_accept_w;
  logic [N*DW-1:0] west_input;
  logic [N-1:0]    west_valid;
  logic [N-1:0]    west_switch;
  logic            busy;
  logic            tile_done;
`ifdef SA_FEEDER_PERF_EN
  logic [31:0]     tile_count;
  logic [31:0]     stall_cycles;
`endif

  sa_edge_feeder #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .north_weight(north_weight), .north_accept_w(north_accept_w),
    .west_input(west_input), .west_valid(west_valid), .west_switch(west_switch),
    .busy(busy), .tile_done(tile_done)
`ifdef SA_FEEDER_PERF_EN
    , .tile_count(tile_count), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [N-1:0]    exp_na [MAXC];
  logic [N*DW-1:0] exp_nw [MAXC];
  logic [N-1:0]    exp_wv [MAXC];
  logic [N-1:0]    exp_ws [MAXC];
  logic [N*DW-1:0] exp_wd [MAXC];
  logic            exp_td [MAXC];

  // ph: 0 idle, 1 loading, 2 streaming, 3 draining (value for the current cycle)
  int ph = 0, wcnt = 0, acnt = 0, done_cyc = -1, stalls = 0, tiles = 0;
  bit first_vec = 0;
  bit whs, ahs;
  logic [N*DW-1:0] pe_row [N];
  logic [N*DW-1:0] wbeat  [N];
  logic [N*DW-1:0] avec   [MAXV];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N*DW-1:0] rnd_vec();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < MAXC; c++) begin
      exp_na[c] = '0; exp_nw[c] = '0; exp_wv[c] = '0;
      exp_ws[c] = '0; exp_wd[c] = '0; exp_td[c] = 1'b0;
    end
    ph = 0; wcnt = 0; acnt = 0; done_cyc = -1; first_vec = 0; stalls = 0; tiles = 0;
  endtask

  task automatic cycle_begin();
    @(negedge clk);
    cyc++;
    if (cyc + N + 2 >= MAXC) begin
      $display("FAIL cycle_table got=%0d exp<%0d", cyc, MAXC);
      $fatal(1, "expectation table exhausted");
    end
    if (cyc == done_cyc) begin ph = 0; wcnt = 0; acnt = 0; end
    if (cyc == done_cyc + 1) tiles++;
    chk("north_accept_w", 64'(north_accept_w), 64'(exp_na[cyc]));
    chk("north_weight",   64'(north_weight),   64'(exp_nw[cyc]));
    chk("west_valid",     64'(west_valid),     64'(exp_wv[cyc]));
    chk("west_switch",    64'(west_switch),    64'(exp_ws[cyc]));
    chk("west_input",     64'(west_input),     64'(exp_wd[cyc]));
    chk("tile_done",      64'(tile_done),      64'(exp_td[cyc]));
    chk("busy",           64'(busy),           64'(ph != 0));
    chk("a_ready",        64'(a_ready),        64'(ph == 2));
    if (ph != 0) chk("w_ready", 64'(w_ready), 64'(ph == 1));
`ifdef SA_FEEDER_PERF_EN
    chk("tile_count",   64'(tile_count),   64'(tiles));
    chk("stall_cycles", 64'(stall_cycles), 64'(stalls));
`endif
    if (north_accept_w == '1) begin
      for (int r = N - 1; r > 0; r--) pe_row[r] = pe_row[r-1];
      pe_row[0] = north_weight;
    end
  endtask

  task automatic cycle_end();
    whs = w_valid && w_ready && (ph <= 1);
    ahs = a_valid && a_ready && (ph == 2);
    if ((ph == 1 && !whs) || (ph == 2 && !ahs)) stalls++;
    if (whs) begin
      exp_na[cyc+1] = '1;
      exp_nw[cyc+1] = w_data;
      wcnt++;
      if (ph == 0) ph = 1;
      if (wcnt == N) begin ph = 2; first_vec = 1; end
    end
    if (ahs) begin
      for (int r = 0; r < N; r++) begin
        exp_wv[cyc+1+r][r] = 1'b1;
        exp_ws[cyc+1+r][r] = first_vec;
        exp_wd[cyc+1+r][r*DW +: DW] = a_data[r*DW +: DW];
      end
      first_vec = 0;
      acnt++;
      if (a_last) begin
        ph = 3;
        done_cyc = cyc + N + 1;
        exp_td[done_cyc] = 1'b1;
      end
    end
  endtask

  // w_hole: one idle cycle before that weight beat; a_hole: two idle cycles before that vector.
  task automatic run_tile(input int nvec, input int gap_pct, input int w_hole, input int a_hole, input int rst_after);
    bit started = 0, finished = 0, wh_done = 0;
    int ah_cnt = 0;
    for (int budget = 0; budget < 300 && !finished; budget++) begin
      cycle_begin();
      if (started && ph == 0) begin
        w_valid = 1'b0; a_valid = 1'b0;
        cycle_end();
        finished = 1;
      end else if (rst_after >= 0 && ph == 2 && acnt == rst_after) begin
        w_valid = 1'b0; a_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_north_accept_w", 64'(north_accept_w), 64'd0);
        chk("rst_north_weight",   64'(north_weight),   64'd0);
        chk("rst_west_valid",     64'(west_valid),     64'd0);
        chk("rst_west_input",     64'(west_input),     64'd0);
        chk("rst_west_switch",    64'(west_switch),    64'd0);
        chk("rst_busy",           64'(busy),           64'd0);
        chk("rst_a_ready",        64'(a_ready),        64'd0);
        chk("rst_w_ready",        64'(w_ready),        64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        finished = 1;
      end else begin
        if (ph <= 1 && wcnt < N) begin
          if (w_hole == wcnt && !wh_done) begin
            w_valid = 1'b0; wh_done = 1;
          end else begin
            w_valid = (int'($urandom_range(99)) >= gap_pct);
          end
          w_data = w_valid ? wbeat[wcnt] : rnd_vec();
        end else begin
          w_valid = 1'($urandom_range(1));
          w_data  = rnd_vec();
        end
        if (ph == 2 && acnt < nvec) begin
          if (a_hole == acnt && ah_cnt < 2) begin
            a_valid = 1'b0; ah_cnt++;
          end else begin
            a_valid = (int'($urandom_range(99)) >= gap_pct);
          end
          a_data = a_valid ? avec[acnt] : rnd_vec();
          a_last = a_valid ? (acnt == nvec - 1) : 1'($urandom_range(1));
        end else begin
          a_valid = 1'($urandom_range(1));
          a_data  = rnd_vec();
          a_last  = 1'($urandom_range(1));
        end
        cycle_end();
        if (ph != 0) started = 1;
      end
    end
    chk("tile_finished", 64'(finished), 64'd1);
    if (finished && rst_after < 0)
      for (int r = 0; r < N; r++) chk("pe_row_after_load", 64'(pe_row[r]), 64'(wbeat[N-1-r]));
  endtask

  task automatic fixed_weights();
    for (int k = 0; k < N; k++)
      for (int c = 0; c < N; c++) wbeat[k][c*DW +: DW] = DW'(40 - 10*k + c);
  endtask

  task automatic random_data();
    for (int k = 0; k < N; k++) wbeat[k] = rnd_vec();
    for (int v = 0; v < MAXV; v++) avec[v] = rnd_vec();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    for (int r = 0; r < N; r++) pe_row[r] = '0;
    #1;
    chk("reset_w_ready", 64'(w_ready), 64'd0);
    chk("reset_a_ready", 64'(a_ready), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_north", 64'({north_weight, north_accept_w}), 64'd0);
    chk("reset_west", 64'({west_input, west_valid, west_switch}), 64'd0);
    chk("reset_tile_done", 64'(tile_done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    fixed_weights();
    for (int r = 0; r < N; r++) begin
      avec[0][r*DW +: DW] = DW'(r + 1);
      avec[1][r*DW +: DW] = DW'(r + 5);
    end
    run_tile(2, 0, -1, -1, -1);   // back-to-back load and two-vector skew
    run_tile(2, 0, 2, -1, -1);    // gapped load
    random_data();
    run_tile(5, 0, -1, 2, -1);    // two-cycle bubble mid-stream
    run_tile(1, 0, -1, -1, -1);   // single-vector tile: switch and last together
    random_data();
    run_tile(3, 0, -1, -1, 1);    // reset after first of three vectors
    fixed_weights();
    run_tile(2, 0, -1, -1, -1);   // fresh load after reset
    for (int i = 0; i < 25; i++) begin
      random_data();
      run_tile(int'($urandom_range(MAXV, 1)), int'($urandom_range(40, 0)), -1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
